// File: rtl/nor_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial NOR adder/subtractor.
// Holds the FSM state encoding, the counter width function and the NOR cell model.
package nor_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of a counter that has to reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

endpackage

// File: rtl/nor_adder_slice.sv
// K-bit ripple adder slice built purely from two-input NOR cells,
// nine per bit in the classic NOR full-adder mapping.
module nor_adder_slice
    import nor_serial_adder_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [K:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < K; i++) begin : g_bit
        logic n1, n2, n3, x, n5, n6, n7;

        // First NOR triplet forms xnor(a, b); the second forms xnor(x, cin) = a ^ b ^ cin.
        assign n1       = nor2(a[i], b[i]);
        assign n2       = nor2(a[i], n1);
        assign n3       = nor2(b[i], n1);
        assign x        = nor2(n2, n3);
        assign n5       = nor2(x, c[i]);
        assign n6       = nor2(x, n5);
        assign n7       = nor2(c[i], n5);
        assign s[i]     = nor2(n6, n7);
        assign c[i+1]   = nor2(n1, n5);
    end

    assign cout  = c[K];
    assign c_msb = c[K-1];

endmodule

// File: rtl/nor_serial_adder.sv
// W-bit adder/subtractor that processes K bits per clock through one NOR slice,
// with valid/ready handshakes on both the operand and result sides.
module nor_serial_adder
    import nor_serial_adder_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int N  = W / K;
    localparam int CW = cnt_width(N);

    if (W < 1 || K < 1 || K > W || (W % K) != 0) begin : g_bad_params
        $error("nor_serial_adder: need 1 <= K <= W and W %% K == 0 (W=%0d K=%0d)", W, K);
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q, ovf_q;
    logic [K-1:0]    slice_a, slice_b, slice_s;
    logic            slice_cout, slice_cmsb;
    logic            accept, last;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CW'(N - 1));

    assign slice_a = a_q[int'(cnt_q) * K +: K];
    assign slice_b = b_q[int'(cnt_q) * K +: K];

    nor_adder_slice #(.K(K)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    always_comb begin
        // NOTE: state_d gets its default before the case so every path assigns it and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            carry_q <= sub;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[int'(cnt_q) * K +: K] <= slice_s;
            carry_q <= slice_cout;
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                cout_q <= slice_cout;
                ovf_q  <= slice_cmsb ^ slice_cout;
            end
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on acceptance before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nor_serial_adder.sv
// Directed and randomised checks of nor_serial_adder for K = 1, 4 and 16 at W = 16.
module tb_nor_serial_adder;

    localparam int W  = 16;
    localparam int NI = 3;

    function automatic int k_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : 16;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_s  [NI];
    logic         in_ready_s  [NI];
    logic [W-1:0] a_s         [NI];
    logic [W-1:0] b_s         [NI];
    logic         sub_s       [NI];
    logic         out_valid_s [NI];
    logic         out_ready_s [NI];
    logic [W-1:0] sum_s       [NI];
    logic         cout_s      [NI];
    logic         ovf_s       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        nor_serial_adder #(.W(W), .K(k_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .a         (a_s[g]),
            .b         (b_s[g]),
            .sub       (sub_s[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .sum       (sum_s[g]),
            .cout      (cout_s[g]),
            .ovf       (ovf_s[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference result {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] bp;
        logic [W:0]   t;
        logic         o;
        bp = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bp} + (W+1)'(sub);
        o  = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
        return {o, t[W], t[W-1:0]};
    endfunction

    task automatic wait_ready(input int g);
        int waitc = 0;
        while (!in_ready_s[g] && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check($sformatf("k%0d_in_ready", k_of(g)), in_ready_s[g], 1'b1);
    endtask

    task automatic wait_valid(input int g, output int lat);
        lat = 0;
        while (!out_valid_s[g] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic op_check(input string tag, input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] es, input logic ec, input logic eo,
                            output int acc);
        int lat;
        @(negedge clk);
        wait_ready(g);
        a_s[g] = a; b_s[g] = b; sub_s[g] = sub; in_valid_s[g] = 1'b1;
        @(posedge clk);
        acc = cyc;
        @(negedge clk);
        in_valid_s[g] = 1'b0;
        a_s[g] = W'($urandom); b_s[g] = W'($urandom); sub_s[g] = 1'($urandom);
        wait_valid(g, lat);
        check({tag, "_lat"},  lat, 16 / k_of(g));
        check({tag, "_sum"},  sum_s[g], es);
        check({tag, "_cout"}, cout_s[g], ec);
        check({tag, "_ovf"},  ovf_s[g], eo);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0, acc1, lat;
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [W+1:0] exp;

        for (int g = 0; g < NI; g++) begin
            in_valid_s[g] = 1'b0; out_ready_s[g] = 1'b1;
            a_s[g] = '0; b_s[g] = '0; sub_s[g] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  in_ready_s[1], 1'b0);
        check("rst_out_valid", out_valid_s[1], 1'b0);
        check("rst_sum",       sum_s[1], 16'h0000);
        check("rst_cout",      cout_s[1], 1'b0);
        check("rst_ovf",       ovf_s[1], 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready_s[1], 1'b1);

        // Directed arithmetic at K = 4
        op_check("add_ffff_1", 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, acc0);
        op_check("add_7fff_1", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, acc1);
        check("init_interval", acc1 - acc0, 6);
        op_check("sub_5_7",    1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, acc0);
        op_check("sub_8000_1", 1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, acc0);

        // Backpressure, with stray in_valid pulses carrying bogus operands
        @(negedge clk);
        out_ready_s[1] = 1'b0;
        wait_ready(1);
        a_s[1] = 16'h1234; b_s[1] = 16'h4321; sub_s[1] = 1'b0; in_valid_s[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_s[1] = 16'hFFFF; b_s[1] = 16'hFFFF; sub_s[1] = 1'b1;
        check("bp_busy_in_ready", in_ready_s[1], 1'b0);
        wait_valid(1, lat);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid_s[1] = i[0];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), out_valid_s[1], 1'b1);
            check($sformatf("bp_hold%0d_sum", i),   sum_s[1], 16'h5555);
            check($sformatf("bp_hold%0d_cout", i),  cout_s[1], 1'b0);
            check($sformatf("bp_hold%0d_ovf", i),   ovf_s[1], 1'b0);
            check($sformatf("bp_hold%0d_ready", i), in_ready_s[1], 1'b0);
        end
        a_s[1] = 16'h0001; b_s[1] = 16'h0002; sub_s[1] = 1'b0; in_valid_s[1] = 1'b1;
        out_ready_s[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", out_valid_s[1], 1'b0);
        check("bp_release_ready", in_ready_s[1], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid_s[1] = 1'b0;
        wait_valid(1, lat);
        check("bp_next_lat", lat, 4);
        check("bp_next_sum", sum_s[1], 16'h0003);

        // Reset during the second RUN cycle
        @(negedge clk);
        wait_ready(1);
        a_s[1] = 16'hFFFF; b_s[1] = 16'hFFFF; sub_s[1] = 1'b0; in_valid_s[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", in_ready_s[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrun_out_valid", out_valid_s[1], 1'b0);
        check("midrun_sum",       sum_s[1], 16'h0000);
        check("midrun_cout",      cout_s[1], 1'b0);
        rst = 1'b0;
        #1;
        check("midrun_in_ready", in_ready_s[1], 1'b1);
        op_check("after_abort", 1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, acc0);

        // Random sweep against the reference model for every slice width
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 1000; i++) begin
                ra  = W'($urandom);
                rb  = W'($urandom);
                rs  = 1'($urandom);
                exp = model(ra, rb, rs);
                op_check($sformatf("k%0d_rand%0d", k_of(g), i), g, ra, rb, rs,
                         exp[W-1:0], exp[W], exp[W+1], acc0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
